// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the five-stage IF/ID/EXE/MEM/WB core.
// Tracks per-stage occupancy and derives allow-in and advance strobes from the
// stage finish signals. Resolves taken jumps (one delay slot), EXE overflow
// exceptions and ERET. Produces the PC redirect and holds EPC and EXL.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_finish,
  input  logic        id_finish,
  input  logic        exe_finish,
  input  logic        mem_finish,
  input  logic        wb_finish,
  input  logic        id_hazard,
  input  logic        exe_jump,
  input  logic [29:0] exe_addr,
  input  logic        exe_of,
  input  logic [31:0] exe_epc,
  input  logic        wb_eret,
  output logic        if_valid,
  output logic        id_valid,
  output logic        exe_valid,
  output logic        mem_valid,
  output logic        wb_valid,
  output logic        if_allow_in,
  output logic        id_allow_in,
  output logic        exe_allow_in,
  output logic        mem_allow_in,
  output logic        wb_allow_in,
  output logic        if_to_id_go,
  output logic        id_to_exe_go,
  output logic        exe_to_mem_go,
  output logic        mem_to_wb_go,
  output logic        wb_retire,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] epc_q,
  output logic        exl
);

  // A jump whose delay slot was still in IF waits here for that slot to move.
  logic        jump_pending_r;
  logic [29:0] jump_target_r;

  // Control-flow events after priority resolution (eret > exc > jmp > pending).
  logic eret_s;
  logic exc_s;
  logic jmp_s;
  logic jmp_now_s;
  logic jmp_defer_s;
  logic pend_fire_s;

  // Allow/go chain, resolved from WB backwards so backpressure ripples upstream.
  assign wb_retire     = wb_valid & wb_finish;
  assign wb_allow_in   = ~wb_valid | wb_finish;
  assign mem_to_wb_go  = mem_valid & mem_finish & wb_allow_in;
  assign mem_allow_in  = ~mem_valid | mem_to_wb_go;
  assign exe_to_mem_go = exe_valid & exe_finish & mem_allow_in & ~exe_of;
  assign exe_allow_in  = ~exe_valid | exe_to_mem_go;
  assign id_to_exe_go  = id_valid & id_finish & exe_allow_in & ~id_hazard;
  assign id_allow_in   = ~id_valid | id_to_exe_go;
  assign if_to_id_go   = if_valid & if_finish & id_allow_in;
  assign if_allow_in   = ~if_valid | if_to_id_go;

  // Exception and jump are mutually exclusive: an overflow blocks exe_to_mem_go.
  assign eret_s      = wb_retire & wb_eret;
  assign exc_s       = exe_valid & exe_finish & exe_of & ~eret_s;
  assign jmp_s       = exe_to_mem_go & exe_jump & ~eret_s;
  assign jmp_now_s   = jmp_s & id_valid;
  assign jmp_defer_s = jmp_s & ~id_valid;
  assign pend_fire_s = jump_pending_r & if_to_id_go & ~eret_s & ~exc_s & ~jmp_s;

  // Select the fetch redirect target for this cycle's winning event.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    if (eret_s) begin
      redirect    = 1'b1;
      redirect_pc = epc_q;
    end else if (exc_s) begin
      redirect    = 1'b1;
      redirect_pc = EXC_VECTOR;
    end else if (jmp_now_s) begin
      redirect    = 1'b1;
      redirect_pc = {exe_addr, 2'b00};
    end else if (pend_fire_s) begin
      redirect    = 1'b1;
      redirect_pc = {jump_target_r, 2'b00};
    end else begin
      redirect    = 1'b0;
      redirect_pc = 32'h0000_0000;
    end
  end

  // Stage occupancy: normal advance, with flushes applied to the younger stages.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_valid  <= 1'b0;
      id_valid  <= 1'b0;
      exe_valid <= 1'b0;
      mem_valid <= 1'b0;
      wb_valid  <= 1'b0;
    end else begin
      wb_valid <= wb_allow_in ? mem_to_wb_go : wb_valid;
      if (eret_s) begin
        if_valid  <= 1'b0;
        id_valid  <= 1'b0;
        exe_valid <= 1'b0;
        mem_valid <= 1'b0;
      end else if (exc_s) begin
        if_valid  <= 1'b0;
        id_valid  <= 1'b0;
        exe_valid <= 1'b0;
        mem_valid <= mem_allow_in ? exe_to_mem_go : mem_valid;
      end else if (jmp_now_s) begin
        // Delay slot in ID proceeds; whatever IF fetched past it is dropped.
        if_valid  <= 1'b0;
        id_valid  <= id_allow_in ? 1'b0 : id_valid;
        exe_valid <= exe_allow_in ? id_to_exe_go : exe_valid;
        mem_valid <= mem_allow_in ? exe_to_mem_go : mem_valid;
      end else begin
        if_valid  <= if_allow_in ? 1'b1 : if_valid;
        id_valid  <= id_allow_in ? if_to_id_go : id_valid;
        exe_valid <= exe_allow_in ? id_to_exe_go : exe_valid;
        mem_valid <= mem_allow_in ? exe_to_mem_go : mem_valid;
      end
    end
  end

  // EPC capture on the first exception; EXL set by exceptions, cleared by ERET.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_q <= 32'h0000_0000;
      exl   <= 1'b0;
    end else if (eret_s) begin
      epc_q <= epc_q;
      exl   <= 1'b0;
    end else if (exc_s && !exl) begin
      epc_q <= exe_epc;
      exl   <= 1'b1;
    end else begin
      epc_q <= epc_q;
      exl   <= exl;
    end
  end

  // Deferred-jump tracking: latch when the delay slot is still in IF.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      jump_pending_r <= 1'b0;
      jump_target_r  <= 30'h0000_0000;
    end else if (eret_s || exc_s) begin
      jump_pending_r <= 1'b0;
      jump_target_r  <= jump_target_r;
    end else if (jmp_defer_s) begin
      jump_pending_r <= 1'b1;
      jump_target_r  <= exe_addr;
    end else if (pend_fire_s) begin
      jump_pending_r <= 1'b0;
      jump_target_r  <= jump_target_r;
    end else begin
      jump_pending_r <= jump_pending_r;
      jump_target_r  <= jump_target_r;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl sequencing, stalls, jumps,
// exceptions, ERET and reset, with hand-computed expectations.
module tb_pipe_ctrl;

  logic        clk;
  logic        resetn;
  logic        if_finish, id_finish, exe_finish, mem_finish, wb_finish;
  logic        id_hazard;
  logic        exe_jump;
  logic [29:0] exe_addr;
  logic        exe_of;
  logic [31:0] exe_epc;
  logic        wb_eret;
  logic        if_valid, id_valid, exe_valid, mem_valid, wb_valid;
  logic        if_allow_in, id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in;
  logic        if_to_id_go, id_to_exe_go, exe_to_mem_go, mem_to_wb_go, wb_retire;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc_q;
  logic        exl;

  int checks = 0;
  int errors = 0;

  pipe_ctrl dut (
    .clk(clk), .resetn(resetn),
    .if_finish(if_finish), .id_finish(id_finish), .exe_finish(exe_finish),
    .mem_finish(mem_finish), .wb_finish(wb_finish),
    .id_hazard(id_hazard), .exe_jump(exe_jump), .exe_addr(exe_addr),
    .exe_of(exe_of), .exe_epc(exe_epc), .wb_eret(wb_eret),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
    .if_allow_in(if_allow_in), .id_allow_in(id_allow_in), .exe_allow_in(exe_allow_in),
    .mem_allow_in(mem_allow_in), .wb_allow_in(wb_allow_in),
    .if_to_id_go(if_to_id_go), .id_to_exe_go(id_to_exe_go), .exe_to_mem_go(exe_to_mem_go),
    .mem_to_wb_go(mem_to_wb_go), .wb_retire(wb_retire),
    .redirect(redirect), .redirect_pc(redirect_pc), .epc_q(epc_q), .exl(exl)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_valids(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, if_valid, id_valid, exe_valid, mem_valid, wb_valid}, {27'd0, exp});
  endtask

  initial begin
    resetn     = 1'b0;
    if_finish  = 1'b1; id_finish = 1'b1; exe_finish = 1'b1;
    mem_finish = 1'b1; wb_finish = 1'b1;
    id_hazard  = 1'b0; exe_jump = 1'b0; exe_addr = 30'h0;
    exe_of     = 1'b0; exe_epc = 32'h0; wb_eret = 1'b0;

    // Reset state
    tick(); tick();
    #1;
    chk_valids("rst_valids", 5'b00000);
    chk("rst_allow", {27'd0, if_allow_in, id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in}, 32'h0000_001F);
    chk("rst_go", {27'd0, if_to_id_go, id_to_exe_go, exe_to_mem_go, mem_to_wb_go, wb_retire}, 32'h0);
    chk("rst_redirect", {31'd0, redirect}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_epc", epc_q, 32'h0);
    chk("rst_exl", {31'd0, exl}, 32'h0);

    // Fill from reset: one stage per edge
    resetn = 1'b1;
    tick(); #1; chk_valids("fill_e1", 5'b10000);
    tick(); #1; chk_valids("fill_e2", 5'b11000);
    tick(); #1; chk_valids("fill_e3", 5'b11100);
    tick(); #1; chk_valids("fill_e4", 5'b11110);
    tick(); #1; chk_valids("fill_e5", 5'b11111);
    chk("fill_retire5", {31'd0, wb_retire}, 32'h1);
    tick(); #1; chk("fill_retire6", {31'd0, wb_retire}, 32'h1);

    // Multi-cycle EXE: three cycles without exe_finish
    exe_finish = 1'b0; #1;
    chk("stall_c1_go", {31'd0, exe_to_mem_go}, 32'h0);
    chk("stall_c1_ifgo", {31'd0, if_to_id_go}, 32'h0);
    tick(); #1;
    chk("stall_c2_go", {31'd0, exe_to_mem_go}, 32'h0);
    chk_valids("stall_c2_valids", 5'b11101);
    tick(); #1;
    chk("stall_c3_go", {31'd0, exe_to_mem_go}, 32'h0);
    chk_valids("stall_c3_valids", 5'b11100);
    tick();
    exe_finish = 1'b1; #1;
    chk("stall_c4_go", {31'd0, exe_to_mem_go}, 32'h1);
    chk_valids("stall_c4_valids", 5'b11100);
    tick(); #1; chk_valids("stall_resume", 5'b11110);
    tick(); #1; chk_valids("stall_full", 5'b11111);

    // Jump with delay slot in ID
    exe_jump = 1'b1; exe_addr = 30'h0000_0100; #1;
    chk("jmp_id_redirect", {31'd0, redirect}, 32'h1);
    chk("jmp_id_pc", redirect_pc, 32'h0000_0400);
    tick();
    exe_jump = 1'b0; #1;
    chk_valids("jmp_id_after", 5'b00111);
    chk("jmp_id_redirect_off", {31'd0, redirect}, 32'h0);
    tick(); #1; chk_valids("jmp_id_refetch", 5'b10011);
    tick(); tick(); tick(); tick(); tick(); #1;
    chk_valids("jmp_id_refill", 5'b11111);

    // Jump with delay slot still in IF
    if_finish = 1'b0;
    tick(); #1; chk_valids("jmp_if_idempty", 5'b10111);
    exe_jump = 1'b1; exe_addr = 30'h0000_0200; #1;
    chk("jmp_if_no_redirect", {31'd0, redirect}, 32'h0);
    chk("jmp_if_no_pc", redirect_pc, 32'h0);
    tick();
    exe_jump = 1'b0; #1;
    chk("jmp_if_wait", {31'd0, redirect}, 32'h0);
    tick();
    if_finish = 1'b1; #1;
    chk("jmp_if_fire", {31'd0, redirect}, 32'h1);
    chk("jmp_if_fire_pc", redirect_pc, 32'h0000_0800);
    tick(); #1;
    chk("jmp_if_cleared", {31'd0, redirect}, 32'h0);
    tick(); tick(); tick(); tick(); tick(); #1;
    chk_valids("jmp_if_refill", 5'b11111);

    // Overflow exception with exl=0
    exe_of = 1'b1; exe_epc = 32'hBFC0_0010; #1;
    chk("exc1_redirect", {31'd0, redirect}, 32'h1);
    chk("exc1_pc", redirect_pc, 32'hBFC0_0380);
    tick();
    exe_of = 1'b0; #1;
    chk_valids("exc1_valids", 5'b00001);
    chk("exc1_epc", epc_q, 32'hBFC0_0010);
    chk("exc1_exl", {31'd0, exl}, 32'h1);
    tick(); tick(); tick(); #1;
    chk_valids("exc1_refill", 5'b11100);

    // Second exception while exl=1: EPC holds
    exe_of = 1'b1; exe_epc = 32'h1234_5678; #1;
    chk("exc2_pc", redirect_pc, 32'hBFC0_0380);
    tick();
    exe_of = 1'b0; #1;
    chk("exc2_epc", epc_q, 32'hBFC0_0010);
    chk("exc2_exl", {31'd0, exl}, 32'h1);
    chk_valids("exc2_valids", 5'b00000);
    tick(); tick(); tick(); tick(); tick(); #1;
    chk_valids("exc2_refill", 5'b11111);

    // ERET in WB together with overflow and jump in EXE
    wb_eret = 1'b1; exe_of = 1'b1; exe_jump = 1'b1; exe_addr = 30'h0000_0300; #1;
    chk("eret_redirect", {31'd0, redirect}, 32'h1);
    chk("eret_pc", redirect_pc, 32'hBFC0_0010);
    tick();
    wb_eret = 1'b0; exe_of = 1'b0; exe_jump = 1'b0; #1;
    chk_valids("eret_valids", 5'b00001);
    chk("eret_exl", {31'd0, exl}, 32'h0);
    chk("eret_epc", epc_q, 32'hBFC0_0010);
    chk("eret_redirect_off", {31'd0, redirect}, 32'h0);

    // Asynchronous reset mid-operation clears exl and valids
    tick(); tick(); tick();
    exe_of = 1'b1; exe_epc = 32'h0000_00A0;
    tick();
    exe_of = 1'b0; #1;
    chk("pre_rst_exl", {31'd0, exl}, 32'h1);
    resetn = 1'b0; #1;
    chk("mid_rst_exl", {31'd0, exl}, 32'h0);
    chk("mid_rst_epc", epc_q, 32'h0);
    chk_valids("mid_rst_valids", 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage IF/ID/EXE/MEM/WB core. Owns the per-stage valid bits, generates allow-in and stage-advance strobes from each stage's finish signal, stalls on ID hazards and multi-cycle EXE operations, and resolves control flow. Control-flow events are taken branches/jumps with one delay slot, EXE overflow exceptions and ERET. It drives the PC redirect and holds EPC and the EXL status bit.

## Interface
- EXC_VECTOR, 32'hBFC00380, exception entry address
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- if_finish, id_finish, exe_finish, mem_finish, wb_finish  in  1 each  stage work complete this cycle (exe_finish = ALU finish)
- id_hazard  in  1  ID operand not ready; blocks ID→EXE
- exe_jump  in  1  EXE instruction is a taken branch/jump
- exe_addr  in  30  branch target word address
- exe_of  in  1  EXE overflow trap (already gated by of_allow)
- exe_epc  in  32  byte PC of EXE instruction
- wb_eret  in  1  WB instruction is ERET
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage occupied
- if_allow_in, id_allow_in, exe_allow_in, mem_allow_in, wb_allow_in  out  1 each
- if_to_id_go, id_to_exe_go, exe_to_mem_go, mem_to_wb_go, wb_retire  out  1 each  pipeline-register load enables
- redirect  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  32  new fetch address
- epc_q  out  32  saved exception PC
- exl  out  1  exception level

## Operation
- Allow/go chain, with WB evaluated first:
  - wb_retire = wb_valid & wb_finish
  - wb_allow_in = !wb_valid | wb_finish
  - Each earlier stage X with successor Y: X_go = X_valid & X_finish & Y_allow_in, and X_allow_in = !X_valid | X_go.
  - id_to_exe_go is additionally gated by !id_hazard.
  - exe_to_mem_go is additionally gated by !exe_of.
- Valid update (no flush): X_valid <= X_allow_in ? prev_go : X_valid. if_valid loads 1 whenever if_allow_in, so IF refetches continuously.
- Exception: exc = exe_valid & exe_finish & exe_of.
  - IF, ID and EXE valids cleared next edge; the faulting instruction never enters MEM.
  - MEM/WB drain normally.
  - redirect=1, redirect_pc=EXC_VECTOR.
  - If exl=0: epc_q<=exe_epc and exl<=1. If exl=1: epc_q holds, exl stays 1, redirect still taken.
  - Any pending jump is cleared.
- Jump: jmp = exe_to_mem_go & exe_jump, with one delay slot.
  - If id_valid=1 (delay slot in ID): redirect=1, redirect_pc={exe_addr,2'b00}. IF content squashed (if_valid<=0). Any IF→ID transfer this cycle is cancelled: id_valid<=0 if ID advanced, else ID keeps the delay slot.
  - If id_valid=0 (delay slot still in IF): latch jump_pending=1 and target. Redirect asserts in the first cycle with if_to_id_go=1, pending then clears, and no squash is applied.
- ERET: eret = wb_retire & wb_eret.
  - IF, ID, EXE and MEM valids cleared.
  - exl<=0, redirect=1, redirect_pc=epc_q.
  - Pending jump cleared.
- Priority (same cycle): eret > exc > jmp > pending jump. Lower-priority events in flushed stages are discarded.
- redirect and redirect_pc are combinational from current-cycle events; redirect_pc=0 when redirect=0.

## Timing
- Reset (async, resetn=0): all valids 0, all go/allow-in outputs as derived from valids=0, redirect 0, redirect_pc 0, epc_q 0, exl 0, jump_pending 0.
- First edge after resetn rises: if_valid=1.
- Single-instruction latency with all finishes high: one stage per cycle, so IF→WB retire in 5 cycles.
- Multi-cycle EXE (exe_finish low for N cycles): exe_to_mem_go low for N cycles, then backpressure.
  - ID holds once exe_valid stays.
  - IF holds once id_valid stays.
  - mem_valid drops to 0 (bubble) after MEM drains.
- id_hazard: ID holds; EXE receives a bubble (exe_valid<=0 if EXE advanced).
- Flushes take effect at the next edge. Stages refill from the redirected fetch: if_valid=1 one edge after redirect.
- Reset asserted mid-operation clears everything immediately, including pending jump and exl.

## Test plan
- Reset release, all finish=1, no events: if_valid=1 at edge 1, wb_valid=1 at edge 5, wb_retire every cycle thereafter.
- exe_finish low 3 cycles with full pipe: exe_to_mem_go=0 for 3 cycles, id/if valids held, mem_valid=0 for 3 cycles, flow resumes on cycle 4.
- Jump with id_valid=1, exe_addr=30'h0000_0100: redirect=1, redirect_pc=32'h0000_0400 same cycle; if_valid=0 next edge; delay slot reaches EXE.
- Jump with id_valid=0: no redirect that cycle; redirect asserts exactly on the following if_to_id_go with the latched target.
- exe_of with exe_epc=32'hBFC0_0010, exl=0: redirect_pc=32'hBFC00380, epc_q=32'hBFC0_0010, exl=1, exe_valid=0 next edge, mem_valid unchanged by the event. A second exe_of keeps epc_q unchanged.
- wb_eret retire in the same cycle as exe_of and exe_jump: only ERET acts. redirect_pc=epc_q, exl=0, IF–MEM valids 0 next edge, epc_q unchanged.
